// File: rtl/alu_iter.sv
// alu_iter: parametrised multi-cycle ALU with valid/ready handshakes.
// Single-cycle ops resolve at accept. MUL uses shift-add and DIVU/REMU use
// restoring division, each taking WIDTH iteration steps.
module alu_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             Zero,
    output logic             Sign,
    output logic             Overflow,
    output logic             div_zero,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010,
                           OP_OR   = 4'b0011, OP_XOR  = 4'b0100, OP_NOR  = 4'b0101,
                           OP_SLL  = 4'b0110, OP_SRL  = 4'b0111, OP_SRA  = 4'b1000,
                           OP_SLT  = 4'b1001, OP_SLTU = 4'b1010, OP_MUL  = 4'b1011,
                           OP_DIVU = 4'b1100, OP_REMU = 4'b1101;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    // x: multiplicand / dividend-then-quotient; y: multiplier / divisor;
    // acc: product / partial remainder
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cy_q, cy_d, zf_q, zf_d, sf_q, sf_d, ov_q, ov_d;
    logic             dz_q, dz_d, il_q, il_d, ov_valid_q, ov_valid_d;

    // Single-cycle datapath results, computed from the live inputs at accept
    logic [WIDTH-1:0] sc_res;
    logic             sc_cy, sc_ov, sc_dz, sc_il;
    logic [WIDTH:0]   add_w, sub_w;
    logic [SHW-1:0]   shamt;

    // Iteration step values
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx, quo_nx, acc_m, it_res;

    assign in_ready  = enable && (state_q == IDLE);
    assign out_valid = ov_valid_q;
    assign out       = out_q;
    assign carryout  = cy_q;
    assign Zero      = zf_q;
    assign Sign      = sf_q;
    assign Overflow  = ov_q;
    assign div_zero  = dz_q;
    assign illegal   = il_q;

    // Single-cycle ALU: arithmetic, logic, shifts, compares, divide-by-zero, illegal
    always_comb begin
        add_w  = {1'b0, A} + {1'b0, B};
        sub_w  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        shamt  = B[SHW-1:0];
        sc_res = '0;
        sc_cy  = 1'b0;
        sc_ov  = 1'b0;
        sc_dz  = 1'b0;
        sc_il  = 1'b0;
        case (sel)
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_cy  = add_w[WIDTH];
                sc_ov  = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_cy  = sub_w[WIDTH];
                sc_ov  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_NOR:  sc_res = ~(A | B);
            OP_SLL:  sc_res = A << shamt;
            OP_SRL:  sc_res = A >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(A) >>> shamt);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_MUL:  sc_res = '0;
            OP_DIVU: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
            OP_REMU: begin
                sc_res = A;
                sc_dz  = 1'b1;
            end
            default: sc_il = 1'b1;
        endcase
    end

    // One restoring-division step and one shift-add multiply step
    always_comb begin
        trial  = {acc_q, x_q[WIDTH-1]};
        q_bit  = (trial >= {1'b0, y_q});
        rem_nx = q_bit ? (trial[WIDTH-1:0] - y_q) : trial[WIDTH-1:0];
        quo_nx = {x_q[WIDTH-2:0], q_bit};
        acc_m  = acc_q + (y_q[0] ? x_q : '0);
        case (op_q)
            OP_MUL:  it_res = acc_m;
            OP_DIVU: it_res = quo_nx;
            default: it_res = rem_nx;
        endcase
    end

    // Next-state logic: FSM transitions, operand capture, iteration, result write
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        x_d        = x_q;
        y_d        = y_q;
        acc_d      = acc_q;
        out_d      = out_q;
        cy_d       = cy_q;
        zf_d       = zf_q;
        sf_d       = sf_q;
        ov_d       = ov_q;
        dz_d       = dz_q;
        il_d       = il_q;
        ov_valid_d = ov_valid_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d  = sel;
                        x_d   = A;
                        y_d   = B;
                        acc_d = '0;
                        if ((sel == OP_MUL) ||
                            (((sel == OP_DIVU) || (sel == OP_REMU)) && (B != '0))) begin
                            cnt_d   = SHW'(WIDTH - 1);
                            state_d = ITER;
                        end else begin
                            out_d      = sc_res;
                            cy_d       = sc_cy;
                            zf_d       = (sc_res == '0);
                            sf_d       = sc_res[WIDTH-1];
                            ov_d       = sc_ov;
                            dz_d       = sc_dz;
                            il_d       = sc_il;
                            ov_valid_d = 1'b1;
                            state_d    = DONE;
                        end
                    end
                end
                ITER: begin
                    if (op_q == OP_MUL) begin
                        acc_d = acc_m;
                        x_d   = x_q << 1;
                        y_d   = y_q >> 1;
                    end else begin
                        acc_d = rem_nx;
                        x_d   = quo_nx;
                    end
                    if (cnt_q == '0) begin
                        out_d      = it_res;
                        cy_d       = 1'b0;
                        zf_d       = (it_res == '0);
                        sf_d       = it_res[WIDTH-1];
                        ov_d       = 1'b0;
                        dz_d       = 1'b0;
                        il_d       = 1'b0;
                        ov_valid_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        ov_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs; async reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            cy_q       <= 1'b0;
            zf_q       <= 1'b0;
            sf_q       <= 1'b0;
            ov_q       <= 1'b0;
            dz_q       <= 1'b0;
            il_q       <= 1'b0;
            ov_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            x_q        <= x_d;
            y_q        <= y_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            cy_q       <= cy_d;
            zf_q       <= zf_d;
            sf_q       <= sf_d;
            ov_q       <= ov_d;
            dz_q       <= dz_d;
            il_q       <= il_d;
            ov_valid_q <= ov_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (WIDTH=64).
module tb_alu_iter;
    logic        clk = 1'b0;
    logic        rst_n, enable, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] A, B, out;
    logic [3:0]  sel;
    logic        carryout, Zero, Sign, Overflow, div_zero, illegal;

    int passed = 0;
    int total  = 0;
    int lat;
    logic [63:0] held;

    alu_iter #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .A(A), .B(B), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .carryout(carryout), .Zero(Zero),
        .Sign(Sign), .Overflow(Overflow), .div_zero(div_zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Present an op at a negedge, accept on the next posedge, then count
    // posedges after the accept edge until out_valid is seen.
    task automatic issue(input logic [3:0] s, input logic [63:0] a, input logic [63:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
        sel = s; A = a; B = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = '1; B = '1; sel = 4'b0000;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_cleared", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; sel = '0;
        #12;
        chk("rst_out", out, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags", {58'd0, carryout, Zero, Sign, Overflow, div_zero, illegal}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'b0000, 64'd10, 64'd20);
        chk("add_lat", lat, 0);
        chk("add_out", out, 64'd30);
        chk("add_zc", {62'd0, Zero, carryout}, 64'd0);
        handshake();

        issue(4'b0001, 64'd50, 64'd30);
        chk("sub_out", out, 64'd20);
        chk("sub_carry", {63'd0, carryout}, 64'd1);
        handshake();

        issue(4'b0001, 64'd30, 64'd50);
        chk("subneg_out", out, 64'hFFFF_FFFF_FFFF_FFEC);
        chk("subneg_sc", {62'd0, Sign, carryout}, 64'b10);
        handshake();

        issue(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("addov_out", out, 64'h8000_0000_0000_0000);
        chk("addov_flags", {61'd0, Overflow, Sign, carryout}, 64'b110);
        handshake();

        issue(4'b1100, 64'd100, 64'd25);
        chk("divu_lat", lat, 64);
        chk("divu_out", out, 64'd4);
        handshake();

        issue(4'b1101, 64'd100, 64'd30);
        chk("remu_out", out, 64'd10);
        handshake();

        issue(4'b1011, 64'hFFFF_FFFF, 64'h1_0000_0001);
        chk("mul_lat", lat, 64);
        chk("mul_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
        handshake();

        issue(4'b1100, 64'd100, 64'd0);
        chk("div0_lat", lat, 0);
        chk("div0_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div0_flag", {63'd0, div_zero}, 64'd1);
        handshake();

        issue(4'b1101, 64'd77, 64'd0);
        chk("rem0_out", out, 64'd77);
        handshake();

        issue(4'b1110, 64'd5, 64'd6);
        chk("illegal_out", out, 64'd0);
        chk("illegal_flags", {62'd0, illegal, Zero}, 64'b11);
        handshake();

        issue(4'b1000, 64'h8000_0000_0000_0000, 64'd4);
        chk("sra_out", out, 64'hF800_0000_0000_0000);
        handshake();

        issue(4'b0110, 64'd1, 64'h103);
        chk("sll_mask", out, 64'd8);
        handshake();

        issue(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("slt_out", out, 64'd1);
        handshake();

        issue(4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("sltu_out", out, 64'd0);
        chk("sltu_zero", {63'd0, Zero}, 64'd1);
        handshake();

        // Backpressure: hold DONE 3 cycles with a competing request present
        issue(4'b0100, 64'hF0F0, 64'h0FF0);
        held = out;
        sel = 4'b0000; A = 64'd1; B = 64'd2; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_stable", out, held);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
        end
        chk("xor_out", held, 64'hFF00);
        // Handshake with in_valid still high: new op waits for the next IDLE cycle
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_valid_low", {63'd0, out_valid}, 64'd0);
        chk("hs_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_hs_valid", {63'd0, out_valid}, 64'd1);
        chk("post_hs_out", out, 64'd3);
        handshake();

        // Stall: enable low 5 cycles in the middle of a DIVU
        chk("stall_ready", {63'd0, in_ready}, 64'd1);
        sel = 4'b1100; A = 64'd1000; B = 64'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            lat++;
        end
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        enable = 1'b1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("stall_lat", lat, 69);
        chk("stall_out", out, 64'd142);
        handshake();

        // Reset in the middle of an ITER sequence
        sel = 4'b1100; A = 64'd100; B = 64'd25; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", out, 64'd0);
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_flags", {58'd0, carryout, Zero, Sign, Overflow, div_zero, illegal}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_idle", {63'd0, in_ready}, 64'd1);
        held = 64'd0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) held = 64'd1;
        end
        chk("no_stale_valid", held, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
